// File: rtl/uart_rx.sv
// 8N1-style UART receiver: two-flop synchronizer, mid-bit sampling from an internal
// baud counter, one-cycle VALID / FRAME_ERR strobes and a break-hold state.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 R,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int NW   = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_MID  = BW'(HALF - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_reg;
  logic [BW-1:0]          baud_reg;
  logic [NW-1:0]          bit_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [DATA_BITS-1:0]   data_reg;
  logic                   rx_meta_reg;
  logic                   rx_s_reg;
  logic                   valid_reg;
  logic                   ferr_reg;

  always_ff @(posedge CLK) begin
    if (R) begin
      state_reg   <= S_IDLE;
      baud_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= RX;
      rx_s_reg    <= rx_meta_reg;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          baud_reg <= '0;
          bit_reg  <= '0;
          if (!rx_s_reg) state_reg <= S_START;
        end

        // A start bit that is no longer low at its midpoint is a glitch.
        S_START: begin
          if (baud_reg == BAUD_MID) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            state_reg <= rx_s_reg ? S_IDLE : S_DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg  <= '0;
            shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
            if (bit_reg == BIT_LAST) begin
              bit_reg   <= '0;
              state_reg <= S_STOP;
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (rx_s_reg) begin
              data_reg  <= shift_reg;
              valid_reg <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              ferr_reg  <= 1'b1;
              state_reg <= S_BREAK;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        // Hold here while the line stays low so a break is not read as 0x00 frames.
        S_BREAK: begin
          baud_reg <= '0;
          if (rx_s_reg) state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign DATA      = data_reg;
  assign VALID     = valid_reg;
  assign FRAME_ERR = ferr_reg;
  assign BUSY      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, single byte, back-to-back, glitch, break and
// mid-frame reset, with exact strobe timing checked against the pin-to-VALID latency.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int LAT = 155;           // RX pin falling edge to VALID/FRAME_ERR strobe
  localparam int FRAME = 10 * CPB;

  logic          CLK = 1'b0;
  logic          R   = 1'b1;
  logic          RX  = 1'b1;
  logic [DB-1:0] DATA;
  logic          VALID;
  logic          FRAME_ERR;
  logic          BUSY;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .CLK       (CLK),
    .R         (R),
    .RX        (RX),
    .DATA      (DATA),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int          valid_cnt = 0;
  int          fe_cnt    = 0;
  int          busy_cnt  = 0;
  int          both_cnt  = 0;
  int          v_cyc[$];
  logic [7:0]  v_dat[$];
  int          fe_cyc[$];

  // Event log sampled mid-cycle; the directed sequence checks it afterwards.
  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      valid_cnt++;
      v_cyc.push_back(cyc);
      v_dat.push_back(DATA);
      $display("cycle %0d: VALID data=0x%02h", cyc, DATA);
    end
    if (FRAME_ERR === 1'b1) begin
      fe_cnt++;
      fe_cyc.push_back(cyc);
      $display("cycle %0d: FRAME_ERR", cyc);
    end
    if (BUSY === 1'b1) busy_cnt++;
    if (VALID === 1'b1 && FRAME_ERR === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    int t;
    int base;
    int b0;
    logic [7:0] bb [3];
    logic [7:0] c3;
    bb = '{8'h00, 8'hFF, 8'h3C};
    c3 = 8'hC3;

    // Reset
    R  = 1'b1;
    RX = 1'b1;
    tick(2);
    R = 1'b0;
    @(negedge CLK);
    check("rst_data",  32'(DATA), 32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_ferr",  32'(FRAME_ERR), 32'h0);
    check("rst_busy",  32'(BUSY), 32'h0);
    tick(200);
    @(negedge CLK);
    check("idle_data",      32'(DATA), 32'h0);
    check("idle_busy_cyc",  32'(busy_cnt), 32'd0);
    check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
    check("idle_fe_cnt",    32'(fe_cnt), 32'd0);

    // Single byte 0xA5
    tick(1);
    t = cyc;
    send_byte(8'hA5, 1'b1);
    tick(20);
    @(negedge CLK);
    check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    check("a5_valid_cyc", 32'(v_cyc[0]), 32'(t + LAT));
    check("a5_data_at",   32'(v_dat[0]), 32'hA5);
    check("a5_data_hold", 32'(DATA), 32'hA5);
    check("a5_fe_cnt",    32'(fe_cnt), 32'd0);
    check("a5_busy",      32'(BUSY), 32'h0);

    // Back-to-back 0x00, 0xFF, 0x3C
    tick(1);
    t    = cyc;
    base = valid_cnt;
    for (int k = 0; k < 3; k++) send_byte(bb[k], 1'b1);
    tick(20);
    @(negedge CLK);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'(base + 3));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b_cyc%0d", k), 32'(v_cyc[base + k]), 32'(t + LAT + k * FRAME));
      check($sformatf("b2b_dat%0d", k), 32'(v_dat[base + k]), 32'(bb[k]));
    end
    check("b2b_fe_cnt", 32'(fe_cnt), 32'd0);

    // Glitch: 5 low cycles; START lasts HALF cycles before rejecting it
    tick(1);
    b0   = busy_cnt;
    base = valid_cnt;
    RX = 1'b0;
    tick(5);
    RX = 1'b1;
    tick(40);
    @(negedge CLK);
    check("glitch_busy_cyc",  32'(busy_cnt - b0), 32'(CPB / 2));
    check("glitch_busy",      32'(BUSY), 32'h0);
    check("glitch_valid_cnt", 32'(valid_cnt), 32'(base));
    check("glitch_fe_cnt",    32'(fe_cnt), 32'd0);
    check("glitch_data",      32'(DATA), 32'h3C);

    // Framing error followed by a 500-cycle break, then a good 0x12
    tick(1);
    t    = cyc;
    base = valid_cnt;
    send_byte(8'h55, 1'b0);
    tick(500);
    @(negedge CLK);
    check("brk_fe_cnt",    32'(fe_cnt), 32'd1);
    check("brk_fe_cyc",    32'(fe_cyc[0]), 32'(t + LAT));
    check("brk_valid_cnt", 32'(valid_cnt), 32'(base));
    check("brk_data",      32'(DATA), 32'h3C);
    check("brk_busy",      32'(BUSY), 32'h1);
    tick(1);
    RX = 1'b1;
    tick(10);
    @(negedge CLK);
    check("brk_end_busy",   32'(BUSY), 32'h0);
    check("brk_end_fe_cnt", 32'(fe_cnt), 32'd1);
    tick(1);
    t = cyc;
    send_byte(8'h12, 1'b1);
    tick(20);
    @(negedge CLK);
    check("x12_valid_cnt", 32'(valid_cnt), 32'(base + 1));
    check("x12_valid_cyc", 32'(v_cyc[base]), 32'(t + LAT));
    check("x12_data",      32'(DATA), 32'h12);

    // Reset during data bit 4 of 0xC3, then a clean 0x81
    tick(1);
    base = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    RX = c3[4];
    tick(8);
    R  = 1'b1;
    RX = 1'b1;
    tick(1);
    R = 1'b0;
    @(negedge CLK);
    check("mrst_busy",  32'(BUSY), 32'h0);
    check("mrst_data",  32'(DATA), 32'h0);
    check("mrst_valid", 32'(VALID), 32'h0);
    tick(200);
    @(negedge CLK);
    check("mrst_valid_cnt", 32'(valid_cnt), 32'(base));
    check("mrst_fe_cnt",    32'(fe_cnt), 32'd1);
    tick(1);
    t = cyc;
    send_byte(8'h81, 1'b1);
    tick(20);
    @(negedge CLK);
    check("x81_valid_cnt", 32'(valid_cnt), 32'(base + 1));
    check("x81_valid_cyc", 32'(v_cyc[base]), 32'(t + LAT));
    check("x81_data",      32'(DATA), 32'h81);

    check("valid_ferr_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
